traffic_mode_scheduler: RTL and testbench

//  Top-level mode controller for the intersection. It owns the lamp outputs and the shared

---
 rtl/traffic_mode_scheduler_if.sv | 30 +++
 rtl/traffic_mode_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_traffic_mode_scheduler.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/traffic_mode_scheduler_if.sv
// traffic_mode_scheduler_if - signal bundle between the intersection mode scheduler and
// its surroundings: operator/sensor inputs, the auto-cycle FSM hand-off and the lamp /
// shared-timer outputs. The slave modport is the scheduler's view; master is the
// environment's view. TW must match the TW of the scheduler it connects to.
interface traffic_mode_scheduler_if #(
  parameter int TW = 8
);
  logic [1:0]    mode_sel;      // 00 auto, 01 manual, 10 night, 11 emergency
  logic          manual_step;   // debounced level, rising edge = step request
  logic          time_up;       // shared countdown timer expired
  logic [5:0]    auto_lamps;    // {A_r,A_y,A_g,B_r,B_y,B_g} from the auto FSM
  logic          auto_load;     // auto FSM load_timer
  logic [TW-1:0] auto_preset;   // auto FSM timer_preset
  logic          auto_reset;    // holds the auto FSM in reset outside AUTO
  logic [5:0]    lamps;         // {A_r,A_y,A_g,B_r,B_y,B_g}
  logic          load_timer;    // load strobe to the shared timer
  logic [TW-1:0] timer_preset;  // value loaded with load_timer
  logic [2:0]    state_o;       // CLEAR=0, AUTO=1, MANUAL=2, NIGHT=3, ALLRED=4
  logic          fault;         // watchdog fault

  modport master (
    output mode_sel, manual_step, time_up, auto_lamps, auto_load, auto_preset,
    input  auto_reset, lamps, load_timer, timer_preset, state_o, fault
  );

  modport slave (
    input  mode_sel, manual_step, time_up, auto_lamps, auto_load, auto_preset,
    output auto_reset, lamps, load_timer, timer_preset, state_o, fault
  );
endinterface

// File: rtl/traffic_mode_scheduler.sv
// traffic_mode_scheduler - top-level mode controller for the intersection.
// Owns the lamps and the shared countdown timer's load interface and arbitrates them
// between the auto-cycle FSM, manual stepping, night flashing and emergency all-red.
// Every mode change goes through an all-red CLEAR interval except entry into emergency.
// Optional feature: define TRAFFIC_SCHED_WDOG_EN to add an AUTO-mode time_up watchdog
// (WDOG_SECS) that latches fault and parks the intersection in ALLRED until reset_n.
module traffic_mode_scheduler #(
  parameter int TW              = 8,
  parameter int CLEAR_SECS      = 3,
`ifdef TRAFFIC_SCHED_WDOG_EN
  parameter int WDOG_SECS       = 120,
`endif
  parameter int MAN_YELLOW_SECS = 3
) (
  input  logic                   clk_1hz,
  input  logic                   reset_n,
  traffic_mode_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_AUTO   = 3'd1,
    ST_MANUAL = 3'd2,
    ST_NIGHT  = 3'd3,
    ST_ALLRED = 3'd4
  } state_t;

  typedef enum logic [1:0] {PH_AG, PH_AY, PH_BG, PH_BY} phase_t;

  localparam logic [1:0] MODE_AUTO   = 2'b00;
  localparam logic [1:0] MODE_MANUAL = 2'b01;
  localparam logic [1:0] MODE_NIGHT  = 2'b10;
  localparam logic [1:0] MODE_EMERG  = 2'b11;

  localparam logic [5:0] LAMPS_ALLRED = 6'b100100;
  localparam logic [5:0] LAMPS_AG     = 6'b001100;
  localparam logic [5:0] LAMPS_AY     = 6'b010100;
  localparam logic [5:0] LAMPS_BG     = 6'b100001;
  localparam logic [5:0] LAMPS_BY     = 6'b100010;

  // clr_cnt counts down to zero, so CLEAR lasts exactly CLEAR_SECS cycles
  localparam logic [TW-1:0] CLR_RELOAD = TW'(CLEAR_SECS - 1);
  localparam logic [TW-1:0] MAN_YELLOW = TW'(MAN_YELLOW_SECS);

  state_t        state_reg, state_next;
  phase_t        phase_reg, phase_next;
  logic [TW-1:0] clr_cnt_reg, clr_cnt_next;
  logic [1:0]    mode_reg;
  logic          step_reg;
  logic          step_edge;
  logic          blink_reg, blink_next;
  logic          man_load_reg, man_load_next;
  logic          wdog_trip;

  logic [5:0]    lamps;
  logic          load_timer;
  logic [TW-1:0] timer_preset;
  logic          auto_reset;

  // mode_sel value that keeps a steady state where it is
  function automatic logic [1:0] own_mode(input state_t s);
    case (s)
      ST_AUTO:   return MODE_AUTO;
      ST_MANUAL: return MODE_MANUAL;
      ST_NIGHT:  return MODE_NIGHT;
      default:   return MODE_EMERG;
    endcase
  endfunction

  // steady state reached when a CLEAR interval completes
  function automatic state_t mode_target(input logic [1:0] m);
    case (m)
      MODE_AUTO:   return ST_AUTO;
      MODE_MANUAL: return ST_MANUAL;
      MODE_NIGHT:  return ST_NIGHT;
      default:     return ST_ALLRED;
    endcase
  endfunction

  // step request is the rising edge of the raw level against last cycle's sample
  assign step_edge = bus.manual_step & ~step_reg;

  // next-state logic: mode arbitration, clearance timing, manual phases, night blink
  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    clr_cnt_next  = clr_cnt_reg;
    blink_next    = blink_reg;
    man_load_next = 1'b0;

    case (state_reg)
      ST_CLEAR: begin
        // entry values for MANUAL / NIGHT are prepared while clearing
        phase_next = PH_AG;
        blink_next = 1'b0;
        if (mode_reg == MODE_EMERG) begin
          state_next = ST_ALLRED;
        end else if (clr_cnt_reg == '0) begin
          state_next = mode_target(mode_reg);
        end else begin
          clr_cnt_next = clr_cnt_reg - TW'(1);
        end
      end

      ST_AUTO, ST_MANUAL, ST_NIGHT, ST_ALLRED: begin
        if (mode_reg != own_mode(state_reg)) begin
          // a mode change wins over step/time_up; only emergency skips clearance
          state_next   = (mode_reg == MODE_EMERG) ? ST_ALLRED : ST_CLEAR;
          clr_cnt_next = CLR_RELOAD;
        end else if (state_reg == ST_MANUAL) begin
          case (phase_reg)
            PH_AG: if (step_edge) begin
              phase_next    = PH_AY;
              man_load_next = 1'b1;
            end
            // the yellow load is still in flight while man_load is set, so a stale
            // time_up from the previous timer run must not end the yellow early
            PH_AY: if (bus.time_up && !man_load_reg) phase_next = PH_BG;
            PH_BG: if (step_edge) begin
              phase_next    = PH_BY;
              man_load_next = 1'b1;
            end
            PH_BY: if (bus.time_up && !man_load_reg) phase_next = PH_AG;
          endcase
        end else if (state_reg == ST_NIGHT) begin
          blink_next = ~blink_reg;
        end
      end

      default: begin
        state_next   = ST_CLEAR;
        clr_cnt_next = CLR_RELOAD;
      end
    endcase

    // a watchdog fault parks the intersection in all-red regardless of mode_sel
    if (wdog_trip) state_next = ST_ALLRED;
  end

  // state and input-sample registers
  always_ff @(posedge clk_1hz) begin
    if (!reset_n) begin
      state_reg    <= ST_CLEAR;
      clr_cnt_reg  <= CLR_RELOAD;
      mode_reg     <= MODE_AUTO;
      step_reg     <= 1'b1;
      phase_reg    <= PH_AG;
      blink_reg    <= 1'b0;
      man_load_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clr_cnt_reg  <= clr_cnt_next;
      mode_reg     <= bus.mode_sel;
      step_reg     <= bus.manual_step;
      phase_reg    <= phase_next;
      blink_reg    <= blink_next;
      man_load_reg <= man_load_next;
    end
  end

  // output mux: AUTO hands everything to the auto FSM, other states drive locally
  always_comb begin
    lamps        = LAMPS_ALLRED;
    load_timer   = man_load_reg;
    timer_preset = man_load_reg ? MAN_YELLOW : '0;
    auto_reset   = 1'b1;
    case (state_reg)
      ST_AUTO: begin
        lamps        = bus.auto_lamps;
        load_timer   = bus.auto_load;
        timer_preset = bus.auto_preset;
        auto_reset   = 1'b0;
      end
      ST_MANUAL: begin
        case (phase_reg)
          PH_AG: lamps = LAMPS_AG;
          PH_AY: lamps = LAMPS_AY;
          PH_BG: lamps = LAMPS_BG;
          PH_BY: lamps = LAMPS_BY;
        endcase
      end
      ST_NIGHT: lamps = {1'b0, blink_reg, 2'b00, blink_reg, 1'b0};
      default: ;
    endcase
  end

  assign bus.lamps        = lamps;
  assign bus.load_timer   = load_timer;
  assign bus.timer_preset = timer_preset;
  assign bus.auto_reset   = auto_reset;
  assign bus.state_o      = state_reg;

`ifdef TRAFFIC_SCHED_WDOG_EN
  localparam int WDW = $clog2(WDOG_SECS + 1);

  logic [WDW-1:0] wd_cnt_reg, wd_cnt_next;
  logic           fault_reg, fault_next;

  // watchdog: idle AUTO cycles since the last time_up or auto_load; fault is sticky
  always_comb begin
    wd_cnt_next = '0;
    fault_next  = fault_reg;
    if (state_reg == ST_AUTO && !(bus.time_up || bus.auto_load)) begin
      if (wd_cnt_reg == WDW'(WDOG_SECS - 1)) begin
        fault_next = 1'b1;
      end else begin
        wd_cnt_next = wd_cnt_reg + WDW'(1);
      end
    end
  end

  // watchdog registers, cleared only by reset_n
  always_ff @(posedge clk_1hz) begin
    if (!reset_n) begin
      wd_cnt_reg <= '0;
      fault_reg  <= 1'b0;
    end else begin
      wd_cnt_reg <= wd_cnt_next;
      fault_reg  <= fault_next;
    end
  end

  assign wdog_trip = fault_reg | fault_next;
  assign bus.fault = fault_reg;
`else
  assign wdog_trip = 1'b0;
  assign bus.fault = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_mode_scheduler.sv
// tb_traffic_mode_scheduler - scoreboard bench for traffic_mode_scheduler.
// Each driven cycle pushes the outputs expected in that cycle; a negedge monitor pops
// and compares them. Watchdog scenario is included when TRAFFIC_SCHED_WDOG_EN is defined.
module tb_traffic_mode_scheduler;

  localparam logic [2:0] S_CLR = 3'd0, S_AUTO = 3'd1, S_MAN = 3'd2, S_NGT = 3'd3, S_ARD = 3'd4;
  localparam logic [5:0] L_RR = 6'b100100, L_AG = 6'b001100, L_AY = 6'b010100;
  localparam logic [5:0] L_BG = 6'b100001, L_BY = 6'b100010;
  localparam logic [5:0] L_NB = 6'b010010, L_NO = 6'b000000;
  localparam logic [5:0] L_A1 = 6'b001100, L_A2 = 6'b010001;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [5:0] lamps;
    logic       ld;
    logic [7:0] pre;
    logic       flt;
  } exp_t;

  logic clk_1hz = 1'b0;
  logic reset_n = 1'b0;
  int   err_cnt = 0;
  int   chk_cnt = 0;
  int   txn_cnt = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  traffic_mode_scheduler_if #(.TW(8)) bus();

  traffic_mode_scheduler #(
    .TW(8),
    .CLEAR_SECS(3),
    .MAN_YELLOW_SECS(3)
  ) dut (
    .clk_1hz(clk_1hz),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk_1hz = ~clk_1hz;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive one cycle of inputs and queue the outputs expected during that cycle
  task automatic cyc(input string tag, input logic rn, input logic [1:0] m, input logic stp,
                     input logic tu, input logic [2:0] es, input logic [5:0] el,
                     input logic eld, input logic [7:0] ep, input logic ef = 1'b0);
    exp_t e;
    reset_n         = rn;
    bus.mode_sel    = m;
    bus.manual_step = stp;
    bus.time_up     = tu;
    e.tag = tag; e.st = es; e.lamps = el; e.ld = eld; e.pre = ep; e.flt = ef;
    exp_q.push_back(e);
    @(negedge clk_1hz);
    @(posedge clk_1hz);
    #1;
  endtask

  // monitor: compare DUT outputs mid-cycle against the oldest queued expectation
  always @(negedge clk_1hz) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      txn_cnt++;
      check_eq({mon_e.tag, ".state"}, 32'(bus.state_o), 32'(mon_e.st));
      check_eq({mon_e.tag, ".lamps"}, 32'(bus.lamps), 32'(mon_e.lamps));
      check_eq({mon_e.tag, ".load"}, 32'(bus.load_timer), 32'(mon_e.ld));
      check_eq({mon_e.tag, ".preset"}, 32'(bus.timer_preset), 32'(mon_e.pre));
      check_eq({mon_e.tag, ".auto_reset"}, 32'(bus.auto_reset), 32'(mon_e.st != S_AUTO));
      check_eq({mon_e.tag, ".fault"}, 32'(bus.fault), 32'(mon_e.flt));
      $display("txn %0d %s: state=%0d lamps=%b load=%b preset=%0d auto_reset=%b fault=%b",
               txn_cnt, mon_e.tag, bus.state_o, bus.lamps, bus.load_timer,
               bus.timer_preset, bus.auto_reset, bus.fault);
    end
  end

  initial begin
    bus.mode_sel    = 2'b00;
    bus.manual_step = 1'b0;
    bus.time_up     = 1'b0;
    bus.auto_lamps  = L_A1;
    bus.auto_load   = 1'b1;
    bus.auto_preset = 8'd30;
    reset_n         = 1'b0;
    repeat (2) @(posedge clk_1hz);
    #1;

    // 1: reset state, 3-cycle clearance, then AUTO passthrough
    for (int i = 0; i < 3; i++) cyc("t1_clr", 1, 2'b00, 0, 0, S_CLR, L_RR, 0, 8'd0);
    cyc("t1_auto0", 1, 2'b00, 0, 0, S_AUTO, L_A1, 1, 8'd30);
    bus.auto_lamps = L_A2; bus.auto_load = 1'b0; bus.auto_preset = 8'd5;
    cyc("t1_auto1", 1, 2'b00, 0, 0, S_AUTO, L_A2, 0, 8'd5);

    // 2: AUTO -> MANUAL via CLEAR, step to yellow with one-cycle load, time_up to BG
    cyc("t2_sel", 1, 2'b01, 0, 0, S_AUTO, L_A2, 0, 8'd5);
    cyc("t2_lag", 1, 2'b01, 0, 0, S_AUTO, L_A2, 0, 8'd5);
    for (int i = 0; i < 3; i++) cyc("t2_clr", 1, 2'b01, 0, 0, S_CLR, L_RR, 0, 8'd0);
    cyc("t2_ag", 1, 2'b01, 0, 0, S_MAN, L_AG, 0, 8'd0);
    cyc("t2_step", 1, 2'b01, 1, 0, S_MAN, L_AG, 0, 8'd0);
    cyc("t2_yload", 1, 2'b01, 0, 1, S_MAN, L_AY, 1, 8'd3);
    cyc("t2_ay", 1, 2'b01, 0, 0, S_MAN, L_AY, 0, 8'd0);
    cyc("t2_tu", 1, 2'b01, 0, 1, S_MAN, L_AY, 0, 8'd0);
    cyc("t2_bg", 1, 2'b01, 0, 0, S_MAN, L_BG, 0, 8'd0);

    // 3: B side cycle, then step+time_up together in AY advances exactly once
    cyc("t3_stepb", 1, 2'b01, 1, 0, S_MAN, L_BG, 0, 8'd0);
    cyc("t3_byload", 1, 2'b01, 0, 0, S_MAN, L_BY, 1, 8'd3);
    cyc("t3_tub", 1, 2'b01, 0, 1, S_MAN, L_BY, 0, 8'd0);
    cyc("t3_ag", 1, 2'b01, 0, 0, S_MAN, L_AG, 0, 8'd0);
    cyc("t3_step", 1, 2'b01, 1, 0, S_MAN, L_AG, 0, 8'd0);
    cyc("t3_ayload", 1, 2'b01, 0, 0, S_MAN, L_AY, 1, 8'd3);
    cyc("t3_both", 1, 2'b01, 1, 1, S_MAN, L_AY, 0, 8'd0);
    cyc("t3_bg_hold", 1, 2'b01, 1, 0, S_MAN, L_BG, 0, 8'd0);
    cyc("t3_bg", 1, 2'b01, 0, 0, S_MAN, L_BG, 0, 8'd0);

    // 4: NIGHT blink, emergency with no clearance, exit through CLEAR to AUTO
    cyc("t4_sel", 1, 2'b10, 0, 0, S_MAN, L_BG, 0, 8'd0);
    cyc("t4_lag", 1, 2'b10, 0, 0, S_MAN, L_BG, 0, 8'd0);
    for (int i = 0; i < 3; i++) cyc("t4_clr", 1, 2'b10, 0, 0, S_CLR, L_RR, 0, 8'd0);
    for (int i = 0; i < 3; i++)
      cyc("t4_blink", 1, 2'b10, 0, 0, S_NGT, (i % 2 == 1) ? L_NB : L_NO, 0, 8'd0);
    cyc("t4_emerg", 1, 2'b11, 0, 0, S_NGT, L_NB, 0, 8'd0);
    cyc("t4_emlag", 1, 2'b11, 0, 0, S_NGT, L_NO, 0, 8'd0);
    cyc("t4_allred", 1, 2'b11, 0, 1, S_ARD, L_RR, 0, 8'd0);
    cyc("t4_exit", 1, 2'b00, 0, 0, S_ARD, L_RR, 0, 8'd0);
    cyc("t4_exlag", 1, 2'b00, 0, 0, S_ARD, L_RR, 0, 8'd0);
    for (int i = 0; i < 3; i++) cyc("t4_clr2", 1, 2'b00, 0, 0, S_CLR, L_RR, 0, 8'd0);
    cyc("t4_auto", 1, 2'b00, 0, 0, S_AUTO, L_A2, 0, 8'd5);

    // 5: mode change during CLEAR retargets without restarting; emergency aborts CLEAR
    cyc("t5_sel", 1, 2'b01, 0, 0, S_AUTO, L_A2, 0, 8'd5);
    cyc("t5_lag", 1, 2'b01, 0, 0, S_AUTO, L_A2, 0, 8'd5);
    cyc("t5_chg", 1, 2'b10, 0, 0, S_CLR, L_RR, 0, 8'd0);
    cyc("t5_clr1", 1, 2'b10, 0, 0, S_CLR, L_RR, 0, 8'd0);
    cyc("t5_clr2", 1, 2'b10, 0, 0, S_CLR, L_RR, 0, 8'd0);
    cyc("t5_ngt0", 1, 2'b10, 0, 0, S_NGT, L_NO, 0, 8'd0);
    cyc("t5_ngt1", 1, 2'b10, 0, 0, S_NGT, L_NB, 0, 8'd0);
    cyc("t5_ngt2", 1, 2'b00, 0, 0, S_NGT, L_NO, 0, 8'd0);
    cyc("t5_ngt3", 1, 2'b00, 0, 0, S_NGT, L_NB, 0, 8'd0);
    cyc("t5_clr_em", 1, 2'b11, 0, 0, S_CLR, L_RR, 0, 8'd0);
    cyc("t5_clr_em2", 1, 2'b11, 0, 0, S_CLR, L_RR, 0, 8'd0);
    cyc("t5_allred", 1, 2'b11, 0, 0, S_ARD, L_RR, 0, 8'd0);

    // 6: reset mid-operation restarts from the reset state
    cyc("t6_rst", 0, 2'b01, 0, 0, S_ARD, L_RR, 0, 8'd0);
    for (int i = 0; i < 3; i++) cyc("t6_clr", 1, 2'b00, 0, 0, S_CLR, L_RR, 0, 8'd0);
    cyc("t6_auto", 1, 2'b00, 0, 0, S_AUTO, L_A2, 0, 8'd5);

`ifdef TRAFFIC_SCHED_WDOG_EN
    // 7: 120 idle AUTO cycles trip the watchdog; mode_sel is then ignored
    bus.auto_load = 1'b1;
    cyc("t7_load", 1, 2'b00, 0, 0, S_AUTO, L_A2, 1, 8'd5);
    bus.auto_load = 1'b0;
    for (int i = 0; i < 120; i++) cyc("t7_idle", 1, 2'b00, 0, 0, S_AUTO, L_A2, 0, 8'd5);
    for (int i = 0; i < 4; i++) cyc("t7_fault", 1, 2'b01, 0, 0, S_ARD, L_RR, 0, 8'd0, 1'b1);
`endif

    @(negedge clk_1hz);
    #1;
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
